// File: rtl/crc_pkg.sv
// Shared types and helpers for the round-robin CRC scheduler.
package crc_pkg;

   localparam int DEF_LFSR_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERST,
      ST_SHIFT,
      ST_WAITV,
      ST_COLLECT,
      ST_RESP
   } state_t;

   // A single requester still needs a 1-bit id field.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/crc_rr_sched_if.sv
// Requester and response channels of the CRC scheduler.
interface crc_rr_sched_if
   import crc_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int W       = DEF_LFSR_WIDTH
);

   localparam int IW = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*W-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IW-1:0]        rsp_id;
   logic [W-1:0]         rsp_crc;
   logic                 rsp_err;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_crc, rsp_err
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_crc, rsp_err
   );

endinterface

// File: rtl/crc_rr_arbiter.sv
// Round-robin grant: first valid index after the pointer, pointer moves to the grant.
module crc_rr_arbiter
   import crc_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic                          grant_en,
   output logic                          grant_valid,
   output logic [id_width(NUM_REQ)-1:0]  grant_id
);

   localparam int IW = id_width(NUM_REQ);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;

   // Scan from farthest to nearest so the nearest valid index after ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = ptr;
      cand        = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IW'((int'(ptr) + i) % NUM_REQ);
         if (req_valid[cand]) begin
            grant_valid = 1'b1;
            grant_id    = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= IW'(NUM_REQ - 1);
      end else if (grant_en) begin
         ptr <= grant_id;
      end
   end

endmodule

// File: rtl/crc_rr_sched.sv
// Shares one serial CRC engine among NUM_REQ requesters: serialise word, collect CRC, respond.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for any req_valid; grant, latch word, pulse ready
// ST_ERST    | engine reset held low for one cycle
// ST_SHIFT   | word shifted LSB-first into engine, LFSR_WIDTH cycles
// ST_WAITV   | waiting for first eng_valid, bounded by TIMEOUT
// ST_COLLECT | gathering remaining CRC bits on eng_valid cycles
// ST_RESP    | response held until rsp_ready
module crc_rr_sched
   import crc_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int LFSR_WIDTH = DEF_LFSR_WIDTH,
   parameter int TIMEOUT    = 16
) (
   input  logic            clk,
   input  logic            rst,
   crc_rr_sched_if.slave   bus,
   output logic            eng_rst_n,
   output logic            eng_active,
   output logic            eng_data,
   input  logic            eng_crc,
   input  logic            eng_valid,
   output logic            busy
);

   localparam int IW = id_width(NUM_REQ);
   localparam int BW = $clog2(LFSR_WIDTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(LFSR_WIDTH);
   localparam logic [BW-1:0] BIT_PENULT = BW'(LFSR_WIDTH - 1);
   localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT - 1);

   state_t                state;
   logic [LFSR_WIDTH-1:0] word_sr;
   logic [LFSR_WIDTH-1:0] crc_sr;
   logic [BW-1:0]         bit_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic                  grant_valid;
   logic                  grant_en;
   logic [IW-1:0]         grant_id;

   assign grant_en = (state == ST_IDLE) && grant_valid;

   crc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (bus.req_valid),
      .grant_en    (grant_en),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         word_sr       <= '0;
         crc_sr        <= '0;
         bit_cnt       <= '0;
         tmo_cnt       <= '0;
         bus.req_ready <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_crc   <= '0;
         bus.rsp_err   <= 1'b0;
         eng_rst_n     <= 1'b0;
         eng_active    <= 1'b0;
         eng_data      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         bus.req_ready <= '0;
         case (state)
            ST_IDLE: begin
               eng_rst_n <= 1'b1;
               if (grant_valid) begin
                  bus.req_ready[grant_id] <= 1'b1;
                  word_sr     <= bus.req_data[int'(grant_id)*LFSR_WIDTH +: LFSR_WIDTH];
                  bus.rsp_id  <= grant_id;
                  bus.rsp_err <= 1'b0;
                  eng_rst_n   <= 1'b0;
                  busy        <= 1'b1;
                  state       <= ST_ERST;
               end
            end
            ST_ERST: begin
               eng_rst_n  <= 1'b1;
               eng_active <= 1'b1;
               eng_data   <= word_sr[0];
               word_sr    <= word_sr >> 1;
               bit_cnt    <= BW'(1);
               state      <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (bit_cnt == BIT_LAST) begin
                  eng_active <= 1'b0;
                  eng_data   <= 1'b0;
                  tmo_cnt    <= TMO_LOAD;
                  crc_sr     <= '0;
                  state      <= ST_WAITV;
               end else begin
                  eng_data <= word_sr[0];
                  word_sr  <= word_sr >> 1;
                  bit_cnt  <= bit_cnt + BW'(1);
               end
            end
            ST_WAITV: begin
               if (eng_valid) begin
                  crc_sr  <= {eng_crc, crc_sr[LFSR_WIDTH-1:1]};
                  bit_cnt <= BW'(1);
                  state   <= ST_COLLECT;
               end else if (tmo_cnt == '0) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_crc   <= '0;
                  state         <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt - TW'(1);
               end
            end
            ST_COLLECT: begin
               // Bits enter at the top and shift down, so the first sample lands in bit 0.
               if (eng_valid) begin
                  if (bit_cnt == BIT_PENULT) begin
                     bus.rsp_crc   <= {eng_crc, crc_sr[LFSR_WIDTH-1:1]};
                     bus.rsp_valid <= 1'b1;
                     state         <= ST_RESP;
                  end else begin
                     crc_sr  <= {eng_crc, crc_sr[LFSR_WIDTH-1:1]};
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  busy          <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_rr_sched.sv
// Directed bench for crc_rr_sched with a behavioural serial CRC engine stub.
module tb_crc_rr_sched;

   localparam int W   = 8;
   localparam int N   = 2;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;
   logic eng_rst_n, eng_active, eng_data, busy;
   logic eng_crc   = 1'b0;
   logic eng_valid = 1'b0;

   logic [W-1:0] stub_crc    = '0;
   logic         stub_gap    = 1'b0;
   logic         stub_silent = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   crc_rr_sched_if #(.NUM_REQ(N), .W(W)) bus ();

   crc_rr_sched #(.NUM_REQ(N), .LFSR_WIDTH(W), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .eng_rst_n  (eng_rst_n),
      .eng_active (eng_active),
      .eng_data   (eng_data),
      .eng_crc    (eng_crc),
      .eng_valid  (eng_valid),
      .busy       (busy)
   );

   // Engine stub: once eng_active falls, stream stub_crc LSB-first, optionally with gap cycles.
   logic act_q  = 1'b0;
   logic st_on  = 1'b0;
   logic st_gap = 1'b0;
   int   st_idx = 0;

   always @(negedge clk) begin
      if (eng_rst_n === 1'b0) begin
         st_on     = 1'b0;
         eng_valid = 1'b0;
         eng_crc   = 1'b0;
      end else begin
         if (act_q && !eng_active && !stub_silent) begin
            st_on  = 1'b1;
            st_idx = 0;
            st_gap = 1'b0;
         end
         if (st_on && st_idx < W) begin
            if (stub_gap && st_gap) begin
               eng_valid = 1'b0;
               eng_crc   = ~stub_crc[st_idx];
            end else begin
               eng_valid = 1'b1;
               eng_crc   = stub_crc[st_idx];
               st_idx++;
            end
            st_gap = stub_gap ? ~st_gap : 1'b0;
         end else begin
            st_on     = 1'b0;
            eng_valid = 1'b0;
         end
      end
      act_q = eng_active;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(output int gid);
      int n = 0;
      gid = -1;
      while (bus.req_ready == '0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      check("grant_seen", 32'(bus.req_ready != '0), 1);
      check("grant_onehot", 32'($onehot(bus.req_ready)), 1);
      gid = bus.req_ready[1] ? 1 : 0;
   endtask

   task automatic capture_shift(output logic [W-1:0] bits, output int len);
      int n = 0;
      bits = '0;
      len  = 0;
      while (!eng_active && n < 10) begin
         @(negedge clk);
         n++;
      end
      while (eng_active && len < 20) begin
         if (len < W) bits[len] = eng_data;
         len++;
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (!bus.rsp_valid && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check("rsp_seen", 32'(bus.rsp_valid), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           gid;
      int           len;
      int           cyc;
      logic [W-1:0] bits;

      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b1;

      repeat (3) @(negedge clk);
      bus.req_valid = 2'b11;
      @(negedge clk);
      check("rst_outs", 32'({busy, eng_active, eng_data, bus.rsp_valid, bus.rsp_err,
                             bus.req_ready, bus.rsp_id, bus.rsp_crc}), 0);
      check("rst_eng_rst_n", 32'(eng_rst_n), 0);
      bus.req_valid = '0;
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_eng_rst_n", 32'(eng_rst_n), 1);

      // 1: requester 0, word 3C, engine CRC A5
      stub_crc      = 8'hA5;
      bus.req_data  = {8'h00, 8'h3C};
      bus.req_valid = 2'b01;
      wait_ready(gid);
      check("t1_grant", gid, 0);
      check("t1_erst", 32'(eng_rst_n), 0);
      bus.req_valid = 2'b00;
      bus.req_data  = 16'hFFFF;
      capture_shift(bits, len);
      check("t1_shift_bits", 32'(bits), 32'h3C);
      check("t1_shift_len", len, W);
      wait_rsp(cyc);
      check("t1_collect_cycles", cyc, W);
      check("t1_rsp", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_crc}), 32'({1'b0, 1'b0, 8'hA5}));
      @(negedge clk);
      check("t1_release", 32'({bus.rsp_valid, busy}), 0);

      // 3: engine never answers
      stub_silent   = 1'b1;
      bus.req_data  = {8'h00, 8'h77};
      bus.req_valid = 2'b01;
      wait_ready(gid);
      check("t3_grant", gid, 0);
      bus.req_valid = 2'b00;
      capture_shift(bits, len);
      wait_rsp(cyc);
      check("t3_timeout_cycles", cyc, TMO);
      check("t3_rsp", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_crc}), 32'({1'b0, 1'b1, 8'h00}));
      stub_silent = 1'b0;
      @(negedge clk);

      // 4: gapped engine valid, requester 1, CRC 5A
      stub_gap      = 1'b1;
      stub_crc      = 8'h5A;
      bus.req_data  = {8'hC3, 8'h00};
      bus.req_valid = 2'b10;
      wait_ready(gid);
      check("t4_grant", gid, 1);
      bus.req_valid = 2'b00;
      capture_shift(bits, len);
      check("t4_shift_bits", 32'(bits), 32'hC3);
      wait_rsp(cyc);
      check("t4_collect_cycles", cyc, 2 * W - 1);
      check("t4_rsp", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_crc}), 32'({1'b1, 1'b0, 8'h5A}));
      stub_gap = 1'b0;
      @(negedge clk);

      // 6: consumer stalls 5 cycles while requester 1 waits
      stub_crc      = 8'h96;
      bus.rsp_ready = 1'b0;
      bus.req_data  = {8'hE1, 8'h0F};
      bus.req_valid = 2'b01;
      wait_ready(gid);
      check("t6_grant", gid, 0);
      bus.req_valid = 2'b10;
      capture_shift(bits, len);
      wait_rsp(cyc);
      for (int i = 0; i < 5; i++) begin
         check("t6_hold", 32'({bus.rsp_valid, bus.req_ready, busy, bus.rsp_id, bus.rsp_err, bus.rsp_crc}),
               32'({1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 8'h96}));
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("t6_accept", 32'({bus.rsp_valid, bus.req_ready}), 0);
      @(negedge clk);
      check("t6_next_grant", 32'(bus.req_ready), 32'b10);
      bus.req_valid = 2'b00;
      capture_shift(bits, len);
      check("t6_shift_bits", 32'(bits), 32'hE1);
      wait_rsp(cyc);
      check("t6_rsp2", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_crc}), 32'({1'b1, 1'b0, 8'h96}));
      @(negedge clk);

      // 5: reset in the middle of SHIFT, then pointer must be back at requester 0
      bus.req_data  = {8'h00, 8'hAA};
      bus.req_valid = 2'b01;
      wait_ready(gid);
      check("t5_grant", gid, 0);
      bus.req_valid = 2'b00;
      cyc = 0;
      while (!eng_active && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      check("t5_in_shift", 32'(eng_active), 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_outs", 32'({eng_active, busy, bus.rsp_valid, bus.req_ready}), 0);
      check("t5_rst_eng_rst_n", 32'(eng_rst_n), 0);
      rst = 1'b0;

      // 2: both requesters continuously valid -> 0,1,0,1 with one ready pulse each
      stub_crc      = 8'h3E;
      bus.req_data  = {8'h12, 8'h34};
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_ready(gid);
         check("t2_grant", gid, k % 2);
         @(negedge clk);
         check("t2_single_pulse", 32'(bus.req_ready), 0);
         wait_rsp(cyc);
         check("t2_rsp", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_crc}),
               32'({1'(k % 2), 1'b0, 8'h3E}));
      end
      bus.req_valid = 2'b00;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
